dist_mem: RTL and testbench
===========================

DIST_MEM -- requirements
Module: dist_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, distance word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter RD_LAT, default 2, read latency in cycles; legal values 1 or 2.
REQ-004 The block SHALL have parameter INF_VAL, default all-ones of DATA_W, the "unreached" distance value.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-007 The block SHALL have port init_start, input, 1, a request to fill every entry with INF_VAL.
REQ-008 The block SHALL have port busy, output, 1, high while an init fill is running.
REQ-009 The block SHALL have port w_en, input, 1, an update request.
REQ-010 The block SHALL have port w_min, input, 1, the update mode: 0 = unconditional write, 1 = write only if smaller.
REQ-011 The block SHALL have port w_addr, input, ADDR_W, the update address.
REQ-012 The block SHALL have port w_data, input, DATA_W, the update value.
REQ-013 The block SHALL have port upd_done, output, 1, a one-cycle pulse marking completion of an update.
REQ-014 The block SHALL have port upd_taken, output, 1, qualified by upd_done; 1 = the memory was written.
REQ-015 The block SHALL have port r_en, input, 1, a read request.
REQ-016 The block SHALL have port r_addr, input, ADDR_W, the read address.
REQ-017 The block SHALL have port r_data, output, DATA_W, the read result.
REQ-018 The block SHALL have port r_valid, output, 1, high for one cycle when r_data holds a result.

Function
REQ-019 The controller SHALL have exactly two states, IDLE and INIT; reset enters IDLE.
REQ-020 init_start sampled high at edge t in IDLE SHALL enter INIT and write INF_VAL to addresses 0..DEPTH-1, one per edge, at edges t+1..t+DEPTH, then return to IDLE.
REQ-021 busy SHALL be high from after edge t until after edge t+DEPTH, and low in IDLE.
REQ-022 init_start while busy SHALL be ignored.
REQ-023 w_en and r_en sampled while busy, or at the same edge init_start is accepted, SHALL be dropped with no write, no upd_done and no r_valid.
REQ-024 An update sampled at edge t SHALL register address, data and mode in stage U1.
REQ-025 The stage-U1 update SHALL commit to memory at edge t+1.
REQ-026 upd_done SHALL be high for exactly the cycle following edge t+1.
REQ-027 w_min=0 SHALL always write, with upd_taken=1.
REQ-028 w_min=1 SHALL write only if w_data < stored value (unsigned, strict); on a tie or larger value there SHALL be no write and upd_taken=0.
REQ-029 The compare SHALL use memory contents including any write committed at edge t, so back-to-back updates to the same address SHALL see each other with no stall.
REQ-030 The block SHALL accept one update per cycle; there SHALL be no backpressure.
REQ-031 An update in U1 at the edge init_start is accepted SHALL still commit; init writes start at the following edge with no conflict.
REQ-032 A read sampled at edge t SHALL present r_data with r_valid=1 for the cycle after edge t+RD_LAT-1; r_valid SHALL be low otherwise.
REQ-033 A read SHALL return contents including any update committing at the same edge the read is sampled (write-first via bypass).
REQ-034 The block SHALL accept one read per cycle, fully pipelined, independent of the update path.
REQ-035 Addresses SHALL need no range check; the init counter SHALL stop at DEPTH-1 and never wrap into a second pass.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE, busy=0, upd_done=0, upd_taken=0, r_valid=0, r_data=0, and clear stage U1, the read pipeline and the init counter.
REQ-037 Memory contents SHALL NOT be reset; they are undefined until an init completes.
REQ-038 Reset asserted during INIT SHALL abort the fill; a new init_start is required.

Verification
REQ-039 Init fill: reset, then init_start for 1 cycle -> busy high for exactly 32 cycles; all 32 reads return 0xFF with r_valid 2 cycles after r_en.
REQ-040 Relax: after init, w_min=1 at addr 3 with 0x10, then 0x20, then 0x10 -> upd_taken=1,0,0; read of addr 3 returns 0x10.
REQ-041 Back-to-back relax: consecutive cycles w_min=1 at addr 7 with 0x40 then 0x30 -> both taken; addr 7 reads 0x30.
REQ-042 Bypass: unconditional write 0x55 to addr 9, with r_en to addr 9 sampled at the commit edge -> r_data=0x55.
REQ-043 Collisions: w_en and init_start at the same edge -> update dropped, no upd_done; r_en while busy -> no r_valid.
REQ-044 Reset mid-INIT at counter 10 -> all outputs 0 immediately; a re-run init completes in 32 cycles.

Source files
------------

// File: rtl/dist_mem.sv
// dist_mem: distance memory with an INF init fill, a pipelined "write if smaller"
// update path and a pipelined read path with write-first bypass.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   init_start / busy           start an INF_VAL fill of every entry / fill running
//   w_en, w_min, w_addr, w_data update request (w_min=1: write only if strictly smaller)
//   upd_done, upd_taken         one-cycle completion pulse, and whether memory was written
//   r_en, r_addr                read request
//   r_data, r_valid             read result, valid RD_LAT cycles after the request
module dist_mem #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 5,
    parameter int unsigned       RD_LAT  = 2,
    parameter logic [DATA_W-1:0] INF_VAL = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              busy,
    input  logic              w_en,
    input  logic              w_min,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              upd_done,
    output logic              upd_taken,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              min;
    } upd_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_init_wr;
    logic              w_busy_nxt;
    logic              r_busy;

    logic              w_upd_acc;
    logic              w_rd_acc;
    logic              r_u1_vld;
    upd_t              r_u1;
    logic [DATA_W-1:0] w_u1_old;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd_val;
    logic              r_upd_done;
    logic              r_upd_taken;
    logic              r_rv_out;
    logic [DATA_W-1:0] r_rd_out;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Controller next state: the fill writes r_cnt each INIT cycle and stops at DEPTH-1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_init_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init_start) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_INIT: begin
                w_init_wr = 1'b1;
                if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_INIT);
    end

    // Requests are dropped while filling and on the edge a fill is accepted
    assign w_upd_acc = w_en && (r_state == ST_IDLE) && !init_start;
    assign w_rd_acc  = r_en && (r_state == ST_IDLE) && !init_start;

    // Compare against live memory so a commit on the previous edge is already visible
    assign w_u1_old = r_mem[r_u1.addr];
    assign w_commit = r_u1_vld && (!r_u1.min || (r_u1.data < w_u1_old));

    // Write-first: a read sampled on a commit edge sees the committing value
    assign w_rd_val = (w_commit && (r_u1.addr == r_addr)) ? r_u1.data : r_mem[r_addr];

    // Update stage U1 and completion flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u1_vld    <= 1'b0;
            r_u1        <= '0;
            r_upd_done  <= 1'b0;
            r_upd_taken <= 1'b0;
        end else begin
            r_u1_vld    <= w_upd_acc;
            if (w_upd_acc) begin
                r_u1 <= '{addr: w_addr, data: w_data, min: w_min};
            end
            r_upd_done  <= r_u1_vld;
            r_upd_taken <= w_commit;
        end
    end

    // Storage array, deliberately not reset; fill and commit never coincide
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_cnt] <= INF_VAL;
        end else if (w_commit) begin
            r_mem[r_u1.addr] <= r_u1.data;
        end
    end

    // Read pipeline, data captured at the sampling edge then delayed to RD_LAT
    generate
        if (RD_LAT == 1) begin : g_rd_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rv_out <= 1'b0;
                    r_rd_out <= '0;
                end else begin
                    r_rv_out <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_out <= w_rd_val;
                    end
                end
            end
        end else begin : g_rd_lat2
            logic              r_rv1;
            logic [DATA_W-1:0] r_rd1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rv1    <= 1'b0;
                    r_rd1    <= '0;
                    r_rv_out <= 1'b0;
                    r_rd_out <= '0;
                end else begin
                    r_rv1    <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd1 <= w_rd_val;
                    end
                    r_rv_out <= r_rv1;
                    if (r_rv1) begin
                        r_rd_out <= r_rd1;
                    end
                end
            end
        end
    endgenerate

    assign busy      = r_busy;
    assign upd_done  = r_upd_done;
    assign upd_taken = r_upd_taken;
    assign r_valid   = r_rv_out;
    assign r_data    = r_rd_out;

endmodule

// File: tb/tb_dist_mem.sv
module tb_dist_mem;

    logic       clk;
    logic       rst_n;
    logic       init_start;
    logic       busy;
    logic       w_en;
    logic       w_min;
    logic [4:0] w_addr;
    logic [7:0] w_data;
    logic       upd_done;
    logic       upd_taken;
    logic       r_en;
    logic [4:0] r_addr;
    logic [7:0] r_data;
    logic       r_valid;

    int n_cmp;
    int n_err;

    // Reference contents: what each address must hold once the fill has completed
    logic [7:0] exp_mem [32];

    dist_mem #(
        .DATA_W (8),
        .ADDR_W (5),
        .RD_LAT (2),
        .INF_VAL(8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_start(init_start),
        .busy      (busy),
        .w_en      (w_en),
        .w_min     (w_min),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .upd_done  (upd_done),
        .upd_taken (upd_taken),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .r_valid   (r_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (upd_done !== 1'b0)  begin n_err++; $display("FAIL reset_upd_done got %0b want 0", upd_done); end
        n_cmp++; if (upd_taken !== 1'b0) begin n_err++; $display("FAIL reset_upd_taken got %0b want 0", upd_taken); end
        n_cmp++; if (r_valid !== 1'b0)   begin n_err++; $display("FAIL reset_r_valid got %0b want 0", r_valid); end
        n_cmp++; if (r_data !== 8'h00)   begin n_err++; $display("FAIL reset_r_data got %h want 00", r_data); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_init_fill();
        int n;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        n_cmp++; if (n != 32) begin n_err++; $display("FAIL init_busy_cycles got %0d want 32", n); end
        for (int a = 0; a < 32; a++) exp_mem[a] = 8'hFF;
        // One read per cycle; a read issued at iteration i is visible at iteration i+1
        for (int i = 0; i < 34; i++) begin
            r_en   = (i < 32);
            r_addr = 5'(i);
            step();
            n_cmp++;
            if (r_valid !== ((i >= 1) && (i <= 32))) begin
                n_err++; $display("FAIL init_read_valid i=%0d got %0b", i, r_valid);
            end
            if (i >= 1 && i <= 32) begin
                n_cmp++;
                if (r_data !== exp_mem[i-1]) begin
                    n_err++; $display("FAIL init_read_data addr=%0d got %h want %h", i-1, r_data, exp_mem[i-1]);
                end
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_relax();
        logic [7:0] vals [3];
        logic       want [3];
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h10;
        want[0] = 1'b1;  want[1] = 1'b0;  want[2] = 1'b0;
        w_en = 1'b1; w_min = 1'b1; w_addr = 5'd3;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) w_data = vals[i]; else w_en = 1'b0;
            step();
            n_cmp++;
            if (upd_done !== (i >= 1)) begin n_err++; $display("FAIL relax_done i=%0d got %0b", i, upd_done); end
            if (i >= 1) begin
                n_cmp++;
                if (upd_taken !== want[i-1]) begin
                    n_err++; $display("FAIL relax_taken i=%0d got %0b want %0b", i-1, upd_taken, want[i-1]);
                end
            end
        end
        exp_mem[3] = 8'h10;
        r_en = 1'b1; r_addr = 5'd3;
        step();
        r_en = 1'b0;
        n_cmp++; if (upd_done !== 1'b0) begin n_err++; $display("FAIL relax_done_tail got %0b want 0", upd_done); end
        step();
        n_cmp++; if (r_valid !== 1'b1)      begin n_err++; $display("FAIL relax_rd_valid got %0b want 1", r_valid); end
        n_cmp++; if (r_data !== exp_mem[3]) begin n_err++; $display("FAIL relax_rd_data got %h want %h", r_data, exp_mem[3]); end
    endtask

    task automatic test_back_to_back();
        w_en = 1'b1; w_min = 1'b1; w_addr = 5'd7; w_data = 8'h40;
        step();
        w_data = 8'h30;
        step();
        w_en = 1'b0;
        n_cmp++; if (upd_done !== 1'b1 || upd_taken !== 1'b1) begin n_err++; $display("FAIL b2b_first got done=%0b taken=%0b want 1/1", upd_done, upd_taken); end
        step();
        n_cmp++; if (upd_done !== 1'b1 || upd_taken !== 1'b1) begin n_err++; $display("FAIL b2b_second got done=%0b taken=%0b want 1/1", upd_done, upd_taken); end
        exp_mem[7] = 8'h30;
        r_en = 1'b1; r_addr = 5'd7;
        step();
        r_en = 1'b0;
        step();
        n_cmp++; if (r_valid !== 1'b1 || r_data !== exp_mem[7]) begin n_err++; $display("FAIL b2b_read got v=%0b d=%h want 1/%h", r_valid, r_data, exp_mem[7]); end
    endtask

    task automatic test_bypass();
        w_en = 1'b1; w_min = 1'b0; w_addr = 5'd9; w_data = 8'h55;
        step();
        w_en = 1'b0;
        r_en = 1'b1; r_addr = 5'd9;
        step();
        r_en = 1'b0;
        n_cmp++; if (upd_done !== 1'b1 || upd_taken !== 1'b1) begin n_err++; $display("FAIL bypass_upd got done=%0b taken=%0b want 1/1", upd_done, upd_taken); end
        step();
        exp_mem[9] = 8'h55;
        n_cmp++; if (r_valid !== 1'b1 || r_data !== 8'h55) begin n_err++; $display("FAIL bypass_read got v=%0b d=%h want 1/55", r_valid, r_data); end
    endtask

    task automatic test_collisions();
        int n;
        // An update already in flight when the fill is accepted must still complete
        w_en = 1'b1; w_min = 1'b0; w_addr = 5'd20; w_data = 8'h11;
        step();
        init_start = 1'b1; w_addr = 5'd5; w_data = 8'h01; r_en = 1'b1; r_addr = 5'd0;
        step();
        init_start = 1'b0;
        n_cmp++; if (upd_done !== 1'b1) begin n_err++; $display("FAIL coll_inflight_done got %0b want 1", upd_done); end
        n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL coll_busy got %0b want 1", busy); end
        w_data = 8'h02;
        n = 1;
        while (busy === 1'b1 && n < 100) begin
            init_start = (n == 5);
            step();
            n_cmp++;
            if (upd_done !== 1'b0 || r_valid !== 1'b0) begin
                n_err++; $display("FAIL coll_dropped n=%0d got done=%0b valid=%0b want 0/0", n, upd_done, r_valid);
            end
            if (busy === 1'b1) n++;
        end
        init_start = 1'b0; w_en = 1'b0; r_en = 1'b0;
        n_cmp++; if (n != 32) begin n_err++; $display("FAIL coll_busy_cycles got %0d want 32", n); end
        step();
        n_cmp++; if (upd_done !== 1'b0 || r_valid !== 1'b0) begin n_err++; $display("FAIL coll_after got done=%0b valid=%0b want 0/0", upd_done, r_valid); end
        for (int a = 0; a < 32; a++) exp_mem[a] = 8'hFF;
        r_en = 1'b1; r_addr = 5'd5;
        step();
        r_en = 1'b0;
        step();
        n_cmp++; if (r_valid !== 1'b1 || r_data !== exp_mem[5]) begin n_err++; $display("FAIL coll_read got v=%0b d=%h want 1/%h", r_valid, r_data, exp_mem[5]); end
    endtask

    task automatic test_reset_mid_init();
        int n;
        logic [4:0] addrs [4];
        addrs[0] = 5'd3; addrs[1] = 5'd7; addrs[2] = 5'd9; addrs[3] = 5'd31;
        w_en = 1'b1; w_min = 1'b0; w_addr = 5'd3; w_data = 8'h01;
        step();
        w_en = 1'b0;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy got %0b want 0", busy); end
        n_cmp++; if (upd_done !== 1'b0)  begin n_err++; $display("FAIL midrst_upd_done got %0b want 0", upd_done); end
        n_cmp++; if (upd_taken !== 1'b0) begin n_err++; $display("FAIL midrst_upd_taken got %0b want 0", upd_taken); end
        n_cmp++; if (r_valid !== 1'b0)   begin n_err++; $display("FAIL midrst_r_valid got %0b want 0", r_valid); end
        n_cmp++; if (r_data !== 8'h00)   begin n_err++; $display("FAIL midrst_r_data got %h want 00", r_data); end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_no_resume got %0b want 0", busy); end
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        n_cmp++; if (n != 32) begin n_err++; $display("FAIL rerun_busy_cycles got %0d want 32", n); end
        for (int a = 0; a < 32; a++) exp_mem[a] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            r_en   = (i < 4);
            r_addr = (i < 4) ? addrs[i] : 5'd0;
            step();
            if (i >= 1) begin
                n_cmp++;
                if (r_valid !== 1'b1 || r_data !== exp_mem[addrs[i-1]]) begin
                    n_err++; $display("FAIL rerun_read addr=%0d got v=%0b d=%h want 1/%h", addrs[i-1], r_valid, r_data, exp_mem[addrs[i-1]]);
                end
            end
        end
        r_en = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic       pv, pmin, taken, rv, cw, cm, cr;
        logic [4:0] pa, ca, cra;
        logic [7:0] pd, cd, rval;
        pv = 1'b0; pmin = 1'b0; pa = '0; pd = '0; rv = 1'b0; rval = '0;
        for (int k = 0; k < 402; k++) begin
            cw  = (k < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            cm  = ($urandom_range(0, 3) != 0);
            ca  = 5'($urandom_range(0, 7));
            cd  = 8'($urandom);
            cr  = (k < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            cra = 5'($urandom_range(0, 7));
            w_en = cw; w_min = cm; w_addr = ca; w_data = cd; r_en = cr; r_addr = cra;
            step();
            // The update issued last cycle lands on this edge; a read issued now sees it
            taken = 1'b0;
            if (pv) begin
                taken = !pmin || (pd < exp_mem[pa]);
                if (taken) exp_mem[pa] = pd;
            end
            n_cmp++;
            if (upd_done !== pv) begin n_err++; $display("FAIL rand_done k=%0d got %0b want %0b", k, upd_done, pv); end
            if (pv) begin
                n_cmp++;
                if (upd_taken !== taken) begin n_err++; $display("FAIL rand_taken k=%0d got %0b want %0b", k, upd_taken, taken); end
            end
            n_cmp++;
            if (r_valid !== rv) begin n_err++; $display("FAIL rand_valid k=%0d got %0b want %0b", k, r_valid, rv); end
            if (rv) begin
                n_cmp++;
                if (r_data !== rval) begin n_err++; $display("FAIL rand_data k=%0d got %h want %h", k, r_data, rval); end
            end
            rv = cr; rval = exp_mem[cra];
            pv = cw; pmin = cm; pa = ca; pd = cd;
        end
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; init_start = 1'b0;
        w_en = 1'b0; w_min = 1'b0; w_addr = '0; w_data = '0;
        r_en = 1'b0; r_addr = '0;
        test_reset();
        test_init_fill();
        test_relax();
        test_back_to_back();
        test_bypass();
        test_collisions();
        test_reset_mid_init();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
